record_keeper: RTL and testbench

//  Downstream of the score updater. Captures each player's final Current_Score when

---
 rtl/record_keeper.sv | 108 ++++++++++
 tb/tb_record_keeper.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/record_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | record_keeper: captures each round's final score on game_timeout rise,   |
// | keeps per-player bests and the all-time high for the display mux.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module record_keeper #(
    parameter int NUM_PLAYERS = 4,
    parameter int SCORE_MAX   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_timeout,
    input  logic [6:0] Current_Score,
    input  logic [2:0] player_sel,
    input  logic       clear_records,
    output logic [6:0] Highest_Score,
    output logic [6:0] Personel_Best,
    output logic [2:0] Player_Won,
    output logic       new_record,
    output logic       bad_player
);

    localparam logic [6:0] SCORE_CAP    = 7'(SCORE_MAX);
    localparam logic [3:0] PLAYER_LIMIT = 4'(NUM_PLAYERS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state, state_next;
    logic       timeout_q;
    logic       rise;
    logic       legal;
    logic [6:0] capped;
    logic [6:0] sel_best;
    logic [6:0] best [NUM_PLAYERS];

    assign rise   = game_timeout & ~timeout_q;
    assign capped = (Current_Score > SCORE_CAP) ? SCORE_CAP : Current_Score;
    assign legal  = ({1'b0, player_sel} < PLAYER_LIMIT);

    // An illegal id matches no entry and therefore reads back as zero.
    always_comb begin
        sel_best = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (player_sel == 3'(p)) sel_best = best[p];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise) state_next = COMMIT;
            COMMIT:  state_next = HOLD;
            HOLD:    if (!game_timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            timeout_q <= game_timeout;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) best[p] <= '0;
            Highest_Score <= '0;
            Player_Won    <= '0;
            Personel_Best <= '0;
            new_record    <= 1'b0;
            bad_player    <= 1'b0;
        end else begin
            new_record    <= 1'b0;
            bad_player    <= 1'b0;
            Personel_Best <= sel_best;
            // A commit takes priority over a simultaneous clear request.
            if (state == COMMIT) begin
                if (!legal) begin
                    bad_player <= 1'b1;
                end else begin
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (player_sel == 3'(p) && capped > best[p]) best[p] <= capped;
                    end
                    if (capped > Highest_Score) begin
                        Highest_Score <= capped;
                        Player_Won    <= player_sel;
                        new_record    <= 1'b1;
                    end
                end
            end else if (clear_records) begin
                for (int p = 0; p < NUM_PLAYERS; p++) best[p] <= '0;
                Highest_Score <= '0;
                Player_Won    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_record_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_record_keeper: directed rounds checked against a score-book model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_record_keeper;

    localparam int NP  = 4;
    localparam int CAP = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       game_timeout = 1'b0;
    logic [6:0] Current_Score = '0;
    logic [2:0] player_sel = '0;
    logic       clear_records = 1'b0;
    logic [6:0] Highest_Score;
    logic [6:0] Personel_Best;
    logic [2:0] Player_Won;
    logic       new_record;
    logic       bad_player;

    record_keeper #(.NUM_PLAYERS(NP), .SCORE_MAX(CAP)) dut (
        .clk           (clk),
        .reset         (reset),
        .game_timeout  (game_timeout),
        .Current_Score (Current_Score),
        .player_sel    (player_sel),
        .clear_records (clear_records),
        .Highest_Score (Highest_Score),
        .Personel_Best (Personel_Best),
        .Player_Won    (Player_Won),
        .new_record    (new_record),
        .bad_player    (bad_player)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int newrec_seen = 0;
    int bad_seen = 0;
    bit checking = 1'b0;

    // Score book: what the outputs must read after the latest clock edge.
    int m_best [8];
    int m_high = 0, m_won = 0, m_pb = 0, m_newrec = 0, m_bad = 0;
    bit prev_gt = 1'b0, commit_due = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_book();
        for (int p = 0; p < 8; p++) m_best[p] = 0;
        m_high = 0;
        m_won  = 0;
    endtask

    task automatic model_step();
        int s;
        int sel;
        if (!reset) begin
            model_clear_book();
            m_pb = 0; m_newrec = 0; m_bad = 0;
            prev_gt = 1'b0; commit_due = 1'b0;
            return;
        end
        sel = int'(player_sel);
        m_pb = (sel < NP) ? m_best[sel] : 0;
        m_newrec = 0;
        m_bad = 0;
        if (commit_due) begin
            s = (int'(Current_Score) > CAP) ? CAP : int'(Current_Score);
            if (sel >= NP) begin
                m_bad = 1;
            end else begin
                if (s > m_best[sel]) m_best[sel] = s;
                if (s > m_high) begin
                    m_high = s; m_won = sel; m_newrec = 1;
                end
            end
        end else if (clear_records) begin
            model_clear_book();
        end
        commit_due = game_timeout && !prev_gt && !commit_due;
        prev_gt = game_timeout;
    endtask

    initial begin
        for (int p = 0; p < 8; p++) m_best[p] = 0;
        forever begin
            @(posedge clk or negedge reset);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("Highest_Score", 32'(Highest_Score), 32'(m_high));
                chk("Player_Won",    32'(Player_Won),    32'(m_won));
                chk("Personel_Best", 32'(Personel_Best), 32'(m_pb));
                chk("new_record",    32'(new_record),    32'(m_newrec));
                chk("bad_player",    32'(bad_player),    32'(m_bad));
                if (new_record === 1'b1) newrec_seen++;
                if (bad_player === 1'b1) bad_seen++;
            end
        end
    end

    task automatic play(input int sel, input int score);
        @(posedge clk); #2;
        player_sel    = 3'(sel);
        Current_Score = 7'(score);
        game_timeout  = 1'b1;
        repeat (3) @(posedge clk);
        #2 game_timeout = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic look_at(input int sel);
        @(posedge clk); #2 player_sel = 3'(sel);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #2 clear_records = 1'b1;
        @(posedge clk); #2 clear_records = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 reset = 1'b0;
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2;
        chk("reset_high", 32'(Highest_Score), 0);
        chk("reset_won",  32'(Player_Won), 0);

        // Fresh record, then a tie that must not steal the title.
        play(2, 37);
        chk("t1_high", 32'(Highest_Score), 37);
        chk("t1_won",  32'(Player_Won), 2);
        chk("t1_pb",   32'(Personel_Best), 37);
        chk("t1_pulses", 32'(newrec_seen), 1);
        play(1, 37);
        chk("t2_won", 32'(Player_Won), 2);
        chk("t2_pb",  32'(Personel_Best), 37);
        chk("t2_pulses", 32'(newrec_seen), 1);

        // Lower score keeps the best; oversize score saturates.
        play(2, 20);
        chk("t3_pb_kept", 32'(Personel_Best), 37);
        play(3, 120);
        chk("t3_high_sat", 32'(Highest_Score), 99);
        chk("t3_won", 32'(Player_Won), 3);
        chk("t3_pb", 32'(Personel_Best), 99);
        look_at(1);
        chk("t3_pb1", 32'(Personel_Best), 37);

        pulse_clear();
        chk("clr_high", 32'(Highest_Score), 0);
        chk("clr_pb",   32'(Personel_Best), 0);

        // Timeout held for ten cycles while the score keeps moving.
        @(posedge clk); #2;
        player_sel = 3'd0; Current_Score = 7'd45; game_timeout = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2 Current_Score = 7'(50 + i);
        end
        game_timeout = 1'b0;
        repeat (3) @(posedge clk); #2;
        chk("t4_high", 32'(Highest_Score), 50);
        chk("t4_pulses", 32'(newrec_seen), 3);

        play(5, 50);
        chk("t5_bad", 32'(bad_seen), 1);
        chk("t5_pb", 32'(Personel_Best), 0);
        chk("t5_high", 32'(Highest_Score), 50);

        // Reset while holding, then release with timeout still high.
        @(posedge clk); #2;
        player_sel = 3'd1; Current_Score = 7'd30; game_timeout = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t6_async_high", 32'(Highest_Score), 0);
        chk("t6_async_pb",   32'(Personel_Best), 0);
        chk("t6_async_won",  32'(Player_Won), 0);
        #2 reset = 1'b1;
        repeat (4) @(posedge clk);
        #2 game_timeout = 1'b0;
        repeat (2) @(posedge clk); #2;
        chk("t6_recommit_high", 32'(Highest_Score), 30);
        chk("t6_recommit_won",  32'(Player_Won), 1);
        pulse_clear();
        chk("t6_clr_high", 32'(Highest_Score), 0);
        chk("t6_clr_won",  32'(Player_Won), 0);
        chk("t6_clr_pb",   32'(Personel_Best), 0);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
